// File: rtl/complex_nr_mult_n.sv
// Multi-cycle complex multiplier with 1, 2 or 4 shared multipliers and a valid/ready handshake.
// Define CPLX_MULT_ACC_EN to accumulate successive products (adds acc_clr and ACC_GUARD bits).
module complex_nr_mult_n #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_MULT   = 1,
   parameter bit          SIGNED     = 1'b0,
   parameter int unsigned ACC_GUARD  = 4,
`ifdef CPLX_MULT_ACC_EN
   localparam int unsigned RES_W     = 2 * DATA_WIDTH + 1 + ACC_GUARD
`else
   localparam int unsigned RES_W     = 2 * DATA_WIDTH + 1
`endif
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      sw_rst,
   input  logic                      op_val,
   output logic                      op_ready,
   input  logic [4*DATA_WIDTH-1:0]   op_data,
`ifdef CPLX_MULT_ACC_EN
   input  logic                      acc_clr,
`endif
   input  logic                      res_ready,
   output logic                      res_val,
   output logic [2*RES_W-1:0]        res_data
);

   localparam int unsigned P = 4 / NUM_MULT;
   localparam logic [1:0] LAST_STEP = 2'(P - 1);

   if (NUM_MULT != 1 && NUM_MULT != 2 && NUM_MULT != 4) begin : g_bad_num_mult
      $error("complex_nr_mult_n: NUM_MULT must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {StIdle, StMult, StAdd, StDone} state_e;

   state_e                            state_q, state_d;
   logic   [3:0][DATA_WIDTH-1:0]      op_q;
   logic   [3:0][RES_W-1:0]           prod_q, prod_d;
   logic   [1:0]                      cnt_q;
   logic   [RES_W-1:0]                re_q, im_q, re_d, im_d;
   logic                              accept;
`ifdef CPLX_MULT_ACC_EN
   logic                              clr_q;
`endif

   // Operands are widened to RES_W so the product wraps modulo 2^RES_W
   function automatic logic signed [RES_W-1:0] ext(input logic [DATA_WIDTH-1:0] x);
      logic sb;
      sb = SIGNED & x[DATA_WIDTH-1];
      return {{(RES_W - DATA_WIDTH){sb}}, x};
   endfunction

   assign accept   = (state_q == StIdle) && op_val;
   assign res_data = {re_q, im_q};

   always_comb begin
      state_d  = state_q;
      op_ready = 1'b0;
      res_val  = 1'b0;
      case (state_q)
         StIdle: begin
            op_ready = 1'b1;
            if (op_val) state_d = StMult;
         end
         StMult: if (cnt_q == LAST_STEP) state_d = StAdd;
         StAdd:  state_d = StDone;
         StDone: begin
            res_val = 1'b1;
            if (res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (sw_rst) state_d = StIdle;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Product index order: re1*re2, im1*im2, re1*im2, im1*re2 (op_q: 3=re1 2=im1 1=re2 0=im2)
   always_comb begin
      logic [1:0]            idx;
      logic [DATA_WIDTH-1:0] a, b;
      prod_d = prod_q;
      idx    = '0;
      a      = '0;
      b      = '0;
      for (int m = 0; m < int'(NUM_MULT); m++) begin
         idx = 2'((int'(cnt_q) * int'(NUM_MULT)) + m);
         a   = idx[0] ? op_q[2] : op_q[3];
         b   = (idx[0] ^ idx[1]) ? op_q[0] : op_q[1];
         if (state_q == StMult) prod_d[idx] = RES_W'(ext(a) * ext(b));
      end
   end

   always_comb begin
      logic [RES_W-1:0] base_re, base_im;
      base_re = '0;
      base_im = '0;
`ifdef CPLX_MULT_ACC_EN
      if (!clr_q) begin
         base_re = re_q;
         base_im = im_q;
      end
`endif
      re_d = base_re + prod_q[0] - prod_q[1];
      im_d = base_im + prod_q[2] + prod_q[3];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_q   <= '0;
         prod_q <= '0;
         cnt_q  <= '0;
         re_q   <= '0;
         im_q   <= '0;
`ifdef CPLX_MULT_ACC_EN
         clr_q  <= 1'b0;
`endif
      end else if (sw_rst) begin
         op_q   <= '0;
         prod_q <= '0;
         cnt_q  <= '0;
         re_q   <= '0;
         im_q   <= '0;
`ifdef CPLX_MULT_ACC_EN
         clr_q  <= 1'b0;
`endif
      end else begin
         prod_q <= prod_d;
         if (accept) begin
            op_q  <= op_data;
            cnt_q <= '0;
`ifdef CPLX_MULT_ACC_EN
            clr_q <= acc_clr;
`endif
         end
         if (state_q == StMult) cnt_q <= 2'(cnt_q + 2'd1);
         if (state_q == StAdd) begin
            re_q <= re_d;
            im_q <= im_d;
         end
      end
   end

endmodule

// File: tb/tb_complex_nr_mult_n.sv
// Directed bench for complex_nr_mult_n: four instances cover NUM_MULT 1/2/4 and SIGNED 0/1.
// The accumulation scenario runs only when CPLX_MULT_ACC_EN is defined.
module tb_complex_nr_mult_n;

   localparam int DW = 8;
`ifdef CPLX_MULT_ACC_EN
   localparam int RW = 2 * DW + 1 + 4;
`else
   localparam int RW = 2 * DW + 1;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic sw_rst = 1'b0;
   logic res_ready = 1'b0;
`ifdef CPLX_MULT_ACC_EN
   logic acc_clr = 1'b1;
`endif
   logic [4*DW-1:0] op_data = '0;
   logic [3:0]      op_val = '0;
   logic [3:0]      op_ready, res_val;
   logic [2*RW-1:0] res_data [4];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // 0: N=1 unsigned, 1: N=4 signed, 2: N=2 unsigned, 3: N=4 unsigned
   complex_nr_mult_n #(.DATA_WIDTH(DW), .NUM_MULT(1), .SIGNED(1'b0)) u_n1 (
      .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .op_val(op_val[0]), .op_ready(op_ready[0]),
      .op_data(op_data),
`ifdef CPLX_MULT_ACC_EN
      .acc_clr(acc_clr),
`endif
      .res_ready(res_ready), .res_val(res_val[0]), .res_data(res_data[0]));

   complex_nr_mult_n #(.DATA_WIDTH(DW), .NUM_MULT(4), .SIGNED(1'b1)) u_n4s (
      .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .op_val(op_val[1]), .op_ready(op_ready[1]),
      .op_data(op_data),
`ifdef CPLX_MULT_ACC_EN
      .acc_clr(acc_clr),
`endif
      .res_ready(res_ready), .res_val(res_val[1]), .res_data(res_data[1]));

   complex_nr_mult_n #(.DATA_WIDTH(DW), .NUM_MULT(2), .SIGNED(1'b0)) u_n2 (
      .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .op_val(op_val[2]), .op_ready(op_ready[2]),
      .op_data(op_data),
`ifdef CPLX_MULT_ACC_EN
      .acc_clr(acc_clr),
`endif
      .res_ready(res_ready), .res_val(res_val[2]), .res_data(res_data[2]));

   complex_nr_mult_n #(.DATA_WIDTH(DW), .NUM_MULT(4), .SIGNED(1'b0)) u_n4 (
      .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .op_val(op_val[3]), .op_ready(op_ready[3]),
      .op_data(op_data),
`ifdef CPLX_MULT_ACC_EN
      .acc_clr(acc_clr),
`endif
      .res_ready(res_ready), .res_val(res_val[3]), .res_data(res_data[3]));

   function automatic logic [2*RW-1:0] cplx(input int re, input int im);
      logic [RW-1:0] r, i;
      r = RW'(re);
      i = RW'(im);
      return {r, i};
   endfunction

   // Called 1 time unit after a posedge with instance d idle; returns edges from acceptance to res_val
   task automatic run_op(input int d, input logic [4*DW-1:0] data, output int lat);
      op_data   = data;
      op_val[d] = 1'b1;
      @(posedge clk); #1;
      op_val[d] = 1'b0;
      lat = 0;
      while (!res_val[d] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (op_ready[d] !== 1'b1) begin
            errors++; $display("FAIL reset_op_ready[%0d] got %b want 1", d, op_ready[d]);
         end
         checks++;
         if (res_val[d] !== 1'b0) begin
            errors++; $display("FAIL reset_res_val[%0d] got %b want 0", d, res_val[d]);
         end
         checks++;
         if (res_data[d] !== '0) begin
            errors++; $display("FAIL reset_res_data[%0d] got %h want 0", d, res_data[d]);
         end
      end
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_n1_unsigned();
      int lat;
      run_op(0, {8'd3, 8'd4, 8'd5, 8'd6}, lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL n1_latency got %0d want 5", lat); end
      checks++;
      if (res_data[0] !== cplx(-9, 38)) begin
         errors++; $display("FAIL n1_result got %h want %h", res_data[0], cplx(-9, 38));
      end
      checks++;
      if (op_ready[0] !== 1'b0) begin
         errors++; $display("FAIL n1_op_ready_done got %b want 0", op_ready[0]);
      end
      handshake();
      checks++;
      if (op_ready[0] !== 1'b1 || res_val[0] !== 1'b0) begin
         errors++;
         $display("FAIL n1_after_hs got op_ready=%b res_val=%b want 1 0", op_ready[0], res_val[0]);
      end
      checks++;
      if (res_data[0] !== cplx(-9, 38)) begin
         errors++; $display("FAIL n1_res_held got %h want %h", res_data[0], cplx(-9, 38));
      end
   endtask

   task automatic test_n4_signed();
      int lat;
      run_op(1, 32'h8080_8080, lat);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL n4s_latency got %0d want 2", lat); end
      checks++;
      if (res_data[1] !== cplx(0, 32768)) begin
         errors++; $display("FAIL n4s_result got %h want %h", res_data[1], cplx(0, 32768));
      end
      handshake();
      checks++;
      if (op_ready[1] !== 1'b1) begin
         errors++; $display("FAIL n4s_after_hs got %b want 1", op_ready[1]);
      end
   endtask

   task automatic test_hold();
      int lat;
      run_op(0, {8'd255, 8'd0, 8'd255, 8'd0}, lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL hold_latency got %0d want 5", lat); end
      op_val[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (res_data[0] !== cplx(65025, 0) || op_ready[0] !== 1'b0 || res_val[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold_cycle%0d got data=%h op_ready=%b res_val=%b want %h 0 1",
                     k, res_data[0], op_ready[0], res_val[0], cplx(65025, 0));
         end
         @(posedge clk); #1;
      end
      op_val[0] = 1'b0;
      handshake();
      checks++;
      if (op_ready[0] !== 1'b1 || res_val[0] !== 1'b0) begin
         errors++;
         $display("FAIL hold_release got op_ready=%b res_val=%b want 1 0", op_ready[0], res_val[0]);
      end
   endtask

   task automatic test_sw_rst();
      int lat;
      int seen;
      run_op(2, {8'd3, 8'd4, 8'd5, 8'd6}, lat);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL n2_latency got %0d want 3", lat); end
      checks++;
      if (res_data[2] !== cplx(-9, 38)) begin
         errors++; $display("FAIL n2_result got %h want %h", res_data[2], cplx(-9, 38));
      end
      handshake();
      op_data   = {8'd7, 8'd9, 8'd11, 8'd13};
      op_val[2] = 1'b1;
      @(posedge clk); #1;
      op_val[2] = 1'b0;
      checks++;
      if (op_ready[2] !== 1'b0) begin
         errors++; $display("FAIL swrst_in_mult got op_ready=%b want 0", op_ready[2]);
      end
      sw_rst = 1'b1;
      @(posedge clk); #1;
      sw_rst = 1'b0;
      checks++;
      if (op_ready[2] !== 1'b1 || res_val[2] !== 1'b0) begin
         errors++;
         $display("FAIL swrst_state got op_ready=%b res_val=%b want 1 0", op_ready[2], res_val[2]);
      end
      checks++;
      if (res_data[2] !== '0) begin
         errors++; $display("FAIL swrst_res_data got %h want 0", res_data[2]);
      end
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (res_val[2]) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL swrst_no_result got %0d res_val cycles want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      res_ready = 1'b1;
      op_data   = {8'd2, 8'd1, 8'd3, 8'd1};
      op_val[3] = 1'b1;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (op_ready[3] !== ((k % 4) == 0)) begin
            errors++; $display("FAIL b2b_op_ready k=%0d got %b want %b", k, op_ready[3], (k % 4) == 0);
         end
         checks++;
         if (res_val[3] !== ((k % 4) == 3)) begin
            errors++; $display("FAIL b2b_res_val k=%0d got %b want %b", k, res_val[3], (k % 4) == 3);
         end
         if ((k % 4) == 3) begin
            checks++;
            if (res_data[3] !== cplx(5, 5)) begin
               errors++; $display("FAIL b2b_data k=%0d got %h want %h", k, res_data[3], cplx(5, 5));
            end
         end
         @(posedge clk); #1;
      end
      op_val[3] = 1'b0;
      res_ready = 1'b0;
      @(posedge clk); #1;
   endtask

`ifdef CPLX_MULT_ACC_EN
   task automatic test_acc();
      int lat;
      acc_clr = 1'b1;
      run_op(0, {8'd1, 8'd1, 8'd2, 8'd0}, lat);
      checks++;
      if (res_data[0] !== cplx(2, 2)) begin
         errors++; $display("FAIL acc_first got %h want %h", res_data[0], cplx(2, 2));
      end
      handshake();
      acc_clr = 1'b0;
      run_op(0, {8'd0, 8'd1, 8'd0, 8'd1}, lat);
      acc_clr = 1'b1;
      checks++;
      if (res_data[0] !== cplx(1, 2)) begin
         errors++; $display("FAIL acc_second got %h want %h", res_data[0], cplx(1, 2));
      end
      handshake();
   endtask
`endif

   initial begin
      test_reset();
      test_n1_unsigned();
      test_n4_signed();
      test_hold();
      test_sw_rst();
      test_back_to_back();
`ifdef CPLX_MULT_ACC_EN
      test_acc();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/complex_nr_mult_n.md
COMPLEX_NR_MULT_N -- requirements
Module: complex_nr_mult_n

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bit width of each operand component.
REQ-002 SHALL have parameter NUM_MULT, default 1, meaning number of parallel multipliers; legal values 1, 2, 4; any other value SHALL be an elaboration error.
REQ-003 SHALL have parameter SIGNED, default 0: 1 means two's-complement operands, 0 means unsigned operands.
REQ-004 SHALL have parameter ACC_GUARD, default 4, meaning accumulator guard bits; used only when CPLX_MULT_ACC_EN is defined.
REQ-005 SHALL define derived width RES_W: 2*DATA_WIDTH+1, plus ACC_GUARD when CPLX_MULT_ACC_EN is defined.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- sw_rst  in  1  synchronous software reset, active-high.
- op_val  in  1  operands valid.
- op_ready  out  1  block can accept operands.
- op_data  in  4*DATA_WIDTH  {op1_re, op1_im, op2_re, op2_im}, MSB first.
- res_ready  in  1  consumer ready.
- res_val  out  1  result valid.
- res_data  out  2*RES_W  {result_re, result_im}.
- acc_clr  in  1  start a new accumulation; present only when CPLX_MULT_ACC_EN is defined.

Function
REQ-007 SHALL implement a state machine with states IDLE, MULT, ADD and DONE.
REQ-008 SHALL drive op_ready=1 only in IDLE and res_val=1 only in DONE.
REQ-009 SHALL capture op_data on the edge where op_val&&op_ready (the acceptance edge) and go IDLE->MULT.
REQ-010 SHALL stay in MULT for P=4/NUM_MULT edges, registering NUM_MULT products per edge, then go to ADD.
REQ-011 SHALL compute products in this order: re1*re2, im1*im2, re1*im2, im1*re2. NUM_MULT=2 SHALL pair (re*re, im*im) first, then the two cross products.
REQ-012 SHALL, in ADD, register result_re=re1*re2-im1*im2 and result_im=re1*im2+im1*re2 in RES_W-bit two's complement on the next edge, then go to DONE.
REQ-013 SHALL assert res_val P+1 edges after the acceptance edge: 2 edges for NUM_MULT=4, 5 edges for NUM_MULT=1.
REQ-014 SHALL sign-extend operands when SIGNED=1 and zero-extend them when SIGNED=0; no saturation SHALL be applied.
REQ-015 SHALL hold res_val and res_data stable in DONE while res_ready=0.
REQ-016 SHALL go DONE->IDLE on res_val&&res_ready; no operand SHALL be accepted on that same edge.
REQ-017 SHALL hold res_data at the last result after the output handshake, until the next ADD.
REQ-018 SHALL ignore op_val outside IDLE; captured operands SHALL NOT change during MULT.

Reset
REQ-019 SHALL, on rstn=0, asynchronously enter IDLE, clear all operand, product and result registers, and drive op_ready=1, res_val=0, res_data=0.
REQ-020 SHALL, on sw_rst=1 at an edge, apply the same clearing synchronously, with priority over every handshake in any state.
REQ-021 SHALL discard an operation interrupted by reset or sw_rst in MULT or ADD; no res_val SHALL be produced for it.

Configuration
REQ-022 SHALL, with macro CPLX_MULT_ACC_EN defined, add acc_clr and make ADD register result=previous result + new complex product, wrapping modulo 2^RES_W.
REQ-023 SHALL, with CPLX_MULT_ACC_EN defined, sample acc_clr at the acceptance edge; acc_clr=1 SHALL make that operation start from zero.
REQ-024 SHALL, without CPLX_MULT_ACC_EN, omit acc_clr, keep RES_W=2*DATA_WIDTH+1, and produce each result independently per REQ-012.

Verification
REQ-025 Bench SHALL cover: DATA_WIDTH=8, SIGNED=0, NUM_MULT=1, (3+4j)*(5+6j) -> res_data re=0x1FFF7 (-9), im=0x00026 (38); res_val 5 edges after acceptance.
REQ-026 Bench SHALL cover: SIGNED=1, NUM_MULT=4, (-128-128j)*(-128-128j) -> re=0, im=0x08000; res_val 2 edges after acceptance.
REQ-027 Bench SHALL cover: SIGNED=0, (255+0j)*(255+0j) with res_ready held 0 for 10 cycles -> re=65025, im=0; res_data stable and op_ready=0 throughout; IDLE one edge after res_ready=1.
REQ-028 Bench SHALL cover: sw_rst pulsed during MULT (NUM_MULT=2) -> IDLE next edge, op_ready=1, res_data=0, no res_val for the aborted operation.
REQ-029 Bench SHALL cover: CPLX_MULT_ACC_EN defined, (1+1j)*(2+0j) with acc_clr=1, then (0+1j)*(0+1j) with acc_clr=0 -> results (2+2j), then (1+2j).
REQ-030 Bench SHALL cover: op_val held high continuously with NUM_MULT=4 and res_ready=1 -> one operand accepted per 4 edges (MULT, ADD, DONE, IDLE).
